dimc_18_fixed: RTL and testbench
================================

Name: dimc_18_fixed

Overview:
Digital in-memory-compute (DIMC) macro. It holds a 128x256-bit kernel SRAM and a 4x256-bit feature register file. It works in two modes: plain memory read/write, or a pipelined multiply-accumulate (MAC) of one 1024-bit kernel row against the 1024-bit feature vector. The MAC has a fixed 4-cycle latency and accepts one launch per cycle. Sits between the vector-processor load/store path and its accumulator/activation stage.

Parameters:
NROW, 128, kernel words (32 compute rows x 4 sections)
W, 256, bits per word/section
PSW, 24, partial-sum width

Ports:
RCK  in  1  system clock; all state updates on rising edge
RESETn  in  1  synchronous reset, active-high (1 = reset)
WCK  in  1  write clock; must be tied to RCK; not used functionally (single clock domain)
WCSN  in  1  write chip-select, active-low
WEN  in  1  write enable, active-low
WA  in  7  write address {row[4:0], sec[1:0]}
D  in  256  write data
M  in  256  write bit-mask (1 = bit written)
RCSN  in  1  read/compute chip-select, active-low
RCSN0..RCSN3  in  1 each  section i compute enable, active-low
RA  in  7  read address; compute uses RA[6:2] as row
Q  out  256  memory read data
COMPE  in  1  1 = compute launch, 0 = memory read
MODE  in  2  precision: 00 1b, 01 2b, 10 4b, 11 8b
ADDIN  in  24  accumulate-in added to the sum
MCT  in  8  output shift control (MCT[4:0] used)
FCSN  in  1  feature write select, active-low
FA  in  2  feature section address
FD  in  256  feature write data
READYN  out  1  result-valid strobe, active-low
PSOUT  out  24  partial-sum result
RES_OUT  out  3  quantized result bits [3:1]
SOUT  out  1  quantized result bit [0]

Behaviour:
- Reset (RESETn=1 at an edge):
  - READYN=1; PSOUT=0, RES_OUT=0, SOUT=0, Q=0.
  - All pipeline valid bits cleared; in-flight results are dropped.
  - Kernel SRAM and feature registers are not cleared.
- Write: WCSN=0 & WEN=0 at an edge → mem[WA] <= (mem[WA] & ~M) | (D & M). Takes effect in 1 cycle.
- Feature write: FCSN=0 at an edge → feat[FA] <= FD.
- Read: RCSN=0 & COMPE=0 at an edge → Q <= mem[RA]. Q is valid after that edge (1 cycle); otherwise Q holds its value.
- Compute launch: RCSN=0 & COMPE=1 at edge E0. It captures:
  - the four sections mem[{RA[6:2], s}], s=0..3;
  - the feature sections;
  - MODE, ADDIN and the section enables.
  - Q is not updated on a launch cycle.
- Read-before-write: a launch or read in the same cycle as a write to the same word sees the old data. Same applies to a feature write coinciding with a launch.
- Arithmetic:
  - Concatenate the 4 sections into 1024-bit vectors K and F. A section with RCSNi=1 contributes 0.
  - Split K and F into N-bit unsigned elements, N = 1/2/4/8 by MODE; 1b mode is AND-popcount.
  - PSOUT = sum(Ki*Fi) + ADDIN, mod 2^24.
  - 8b worst case, 128*255*255, fits in 24 bits.
- Output quantization:
  - Let v = PSOUT (signed) >>> MCT[4:0].
  - {RES_OUT,SOUT} = 0 if v<0; 15 if v>15; otherwise v[3:0].
- Pipeline stages:
  - S1 capture;
  - S2 elementwise products;
  - S3 partial adder tree (per section);
  - S4 final sum + ADDIN + quantize into the output registers.
- Latency: a command presented in the cycle ending at E0 is registered into the outputs at edge E3, i.e. READYN=0 four cycles after the command is driven.
- READYN is low for exactly one cycle per result. Back-to-back launches give back-to-back READYN=0 cycles, with results in order and no stalls.
- When no result is valid, READYN=1 and PSOUT/RES_OUT/SOUT hold their last values.
- Simultaneous read and compute are impossible (COMPE selects one). Writes and feature writes may coincide with either.

Decomposition:
- Package dimc_pkg:
  - mode_e enum (MODE_1B, MODE_2B, MODE_4B, MODE_8B);
  - constants NROW, W, PSW, SECTIONS=4;
  - quantize function.
- Sub-module dimc_mac_unit: mode-aware multiply/popcount plus the registered adder tree (S2–S4 arithmetic).
- The top level holds the SRAM, feature registers, control and output registers.

Test Plan:
- Write D=0x…A5A5 (128 bits of A5 in the low half) at WA=0 with M=all-ones, then read RA=0 → Q=0x…A5A5 (upper 128 bits 0) one cycle after the read command.
- Masked write: write all-ones, then write 0 with M=0x0F → word reads all-ones except bits[3:0]=0.
- Kernel row 0 sections = {0x00010001, 0x00010010, 0x00010100, 0x00011000}, feature sec0 = 0x00011111, MODE=10 → READYN=0 exactly 40 ns after the command is driven. PSOUT equals the 4-bit dot product, computed by the bench.
- Rows 0–4 all-ones kernel, all-ones features, MODE=00, five consecutive launches → five consecutive READYN=0 cycles 10 ns apart, each with PSOUT=1024 and {RES_OUT,SOUT}=1111.
- Mixed-mode back-to-back launches (00, 10, 00, 11) → four results on consecutive cycles, each matching its own mode. 8b all-ones row gives PSOUT=128*65025 mod 2^24=8323200.
- Assert reset with two launches in flight → no READYN pulse; all outputs are 0 after reset.

Source files
------------

// File: rtl/dimc_pkg.sv
// Shared types and constants for the DIMC macro: geometry, precision modes,
// the S1 launch record and the output quantizer.
`timescale 1ns/1ps
package dimc_pkg;
  localparam int NROW     = 128;
  localparam int W        = 256;
  localparam int PSW      = 24;
  localparam int SECTIONS = 4;
  localparam int AW       = 7;
  localparam int BYTES    = W / 8;
  localparam int STAGES   = 3;

  typedef enum logic [1:0] {
    MODE_1B = 2'b00,
    MODE_2B = 2'b01,
    MODE_4B = 2'b10,
    MODE_8B = 2'b11
  } mode_e;

  typedef struct packed {
    logic [SECTIONS-1:0][W-1:0] k;
    logic [SECTIONS-1:0][W-1:0] f;
    mode_e                      mode;
    logic [PSW-1:0]             addin;
    logic [4:0]                 mct;
  } mac_req_t;

  // Signed shift, then clamp to the 4-bit range 0..15.
  function automatic logic [3:0] quantize(input logic [PSW-1:0] ps, input logic [4:0] sh);
    logic signed [PSW-1:0] v;
    v = $signed(ps) >>> sh;
    if (v[PSW-1]) return 4'd0;
    if (|v[PSW-2:4]) return 4'hf;
    return v[3:0];
  endfunction
endpackage

// File: rtl/dimc_mac_unit.sv
// S2..S3 MAC arithmetic: byte-granular mode-aware products, per-section
// adder tree, and the final sum with the accumulate-in (combinational S4 input).
`timescale 1ns/1ps
module dimc_mac_unit
  import dimc_pkg::*;
(
  input  logic           clk,
  input  mac_req_t       req,
  output logic [PSW-1:0] psum,
  output logic [4:0]     mct
);
  logic [SECTIONS-1:0][BYTES-1:0][15:0] prod_d, prod_q;
  logic [SECTIONS-1:0][PSW-1:0]         sec_d, sec_q;
  logic [PSW-1:0]                       addin_s2_q, addin_s3_q;
  logic [4:0]                           mct_s2_q, mct_s3_q;

  // Each byte holds 8/N elements whatever the mode, so a byte is the
  // common unit of work; its worst case (8b, 255*255) fits 16 bits.
  function automatic logic [15:0] byte_mac(input logic [7:0] k, input logic [7:0] f,
                                           input mode_e m);
    logic [15:0] acc;
    acc = '0;
    case (m)
      MODE_1B: for (int i = 0; i < 8; i++) acc += 16'(k[i] & f[i]);
      MODE_2B: for (int i = 0; i < 4; i++) acc += 16'(k[2*i+:2]) * 16'(f[2*i+:2]);
      MODE_4B: for (int i = 0; i < 2; i++) acc += 16'(k[4*i+:4]) * 16'(f[4*i+:4]);
      default: acc = 16'(k) * 16'(f);
    endcase
    return acc;
  endfunction

  for (genvar s = 0; s < SECTIONS; s++) begin : g_sec
    for (genvar b = 0; b < BYTES; b++) begin : g_byte
      assign prod_d[s][b] = byte_mac(req.k[s][8*b+:8], req.f[s][8*b+:8], req.mode);
    end
  end

  always_comb begin
    sec_d = '0;
    for (int s = 0; s < SECTIONS; s++)
      for (int b = 0; b < BYTES; b++)
        sec_d[s] = sec_d[s] + PSW'(prod_q[s][b]);
  end

  always_ff @(posedge clk) begin
    prod_q     <= prod_d;
    sec_q      <= sec_d;
    addin_s2_q <= req.addin;
    addin_s3_q <= addin_s2_q;
    mct_s2_q   <= req.mct;
    mct_s3_q   <= mct_s2_q;
  end

  always_comb begin
    psum = addin_s3_q;
    for (int s = 0; s < SECTIONS; s++) psum = psum + sec_q[s];
  end

  assign mct = mct_s3_q;
endmodule

// File: rtl/dimc_18_fixed.sv
// DIMC macro top: kernel SRAM, feature registers, read/launch control,
// valid pipeline and registered result outputs.
`timescale 1ns/1ps
module dimc_18_fixed
  import dimc_pkg::*;
(
  input  logic           RCK,
  input  logic           RESETn,
  input  logic           WCK,
  input  logic           WCSN,
  input  logic           WEN,
  input  logic [AW-1:0]  WA,
  input  logic [W-1:0]   D,
  input  logic [W-1:0]   M,
  input  logic           RCSN,
  input  logic           RCSN0,
  input  logic           RCSN1,
  input  logic           RCSN2,
  input  logic           RCSN3,
  input  logic [AW-1:0]  RA,
  output logic [W-1:0]   Q,
  input  logic           COMPE,
  input  logic [1:0]     MODE,
  input  logic [PSW-1:0] ADDIN,
  input  logic [7:0]     MCT,
  input  logic           FCSN,
  input  logic [1:0]     FA,
  input  logic [W-1:0]   FD,
  output logic           READYN,
  output logic [PSW-1:0] PSOUT,
  output logic [2:0]     RES_OUT,
  output logic           SOUT
);
  logic [W-1:0]               mem_q [NROW];
  logic [SECTIONS-1:0][W-1:0] feat_q;
  logic                       wr_en, rd_en, launch;
  logic [SECTIONS-1:0]        sec_en;
  logic [W-1:0]               wr_word_d, q_d, q_q;
  mac_req_t                   req_d, req_q;
  logic [STAGES:0]            vld_pipe_d, vld_pipe_q;
  logic [PSW-1:0]             ps_d, ps_q, mac_ps;
  logic [4:0]                 mac_mct;
  logic [3:0]                 qnt_d, qnt_q;
  logic                       unused_ok;

  // WCK shares the RCK domain; only MCT[4:0] steers the shifter.
  assign unused_ok = ^{WCK, MCT[7:5]};

  always_comb begin
    wr_en     = !WCSN && !WEN;
    rd_en     = !RCSN && !COMPE;
    launch    = !RCSN && COMPE;
    sec_en    = ~{RCSN3, RCSN2, RCSN1, RCSN0};
    wr_word_d = (mem_q[WA] & ~M) | (D & M);
    q_d       = rd_en ? mem_q[RA] : q_q;

    req_d = req_q;
    if (launch) begin
      for (int s = 0; s < SECTIONS; s++)
        req_d.k[s] = sec_en[s] ? mem_q[{RA[6:2], 2'(s)}] : '0;
      req_d.f     = feat_q;
      req_d.mode  = mode_e'(MODE);
      req_d.addin = ADDIN;
      req_d.mct   = MCT[4:0];
    end

    vld_pipe_d = {vld_pipe_q[STAGES-1:0], launch};
    ps_d       = ps_q;
    qnt_d      = qnt_q;
    if (vld_pipe_q[STAGES-1]) begin
      ps_d  = mac_ps;
      qnt_d = quantize(mac_ps, mac_mct);
    end
  end

  // Storage is not reset; non-blocking updates give read-before-write.
  always_ff @(posedge RCK) begin
    if (wr_en) mem_q[WA] <= wr_word_d;
    if (!FCSN) feat_q[FA] <= FD;
    req_q <= req_d;
  end

  always_ff @(posedge RCK) begin
    if (RESETn) begin
      vld_pipe_q <= '0;
      ps_q       <= '0;
      qnt_q      <= '0;
      q_q        <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      ps_q       <= ps_d;
      qnt_q      <= qnt_d;
      q_q        <= q_d;
    end
  end

  dimc_mac_unit u_mac (
    .clk  (RCK),
    .req  (req_q),
    .psum (mac_ps),
    .mct  (mac_mct)
  );

  assign Q       = q_q;
  assign PSOUT   = ps_q;
  assign RES_OUT = qnt_q[3:1];
  assign SOUT    = qnt_q[0];
  assign READYN  = ~vld_pipe_q[STAGES];
endmodule

// File: tb/tb_dimc_18_fixed.sv
// Directed bench for dimc_18_fixed: memory ops, launch latency, burst
// throughput, mixed modes, quantizer table and reset with work in flight.
`timescale 1ns/1ps
module tb_dimc_18_fixed;
  logic         RCK = 1'b0;
  logic         RESETn, WCSN, WEN, RCSN, RCSN0, RCSN1, RCSN2, RCSN3, COMPE, FCSN;
  logic [6:0]   WA, RA;
  logic [255:0] D, M, FD, Q;
  logic [1:0]   MODE, FA;
  logic [23:0]  ADDIN, PSOUT;
  logic [7:0]   MCT;
  logic         READYN, SOUT;
  logic [2:0]   RES_OUT;

  always #5 RCK = ~RCK;

  dimc_18_fixed dut (
    .RCK(RCK), .RESETn(RESETn), .WCK(RCK), .WCSN(WCSN), .WEN(WEN), .WA(WA),
    .D(D), .M(M), .RCSN(RCSN), .RCSN0(RCSN0), .RCSN1(RCSN1), .RCSN2(RCSN2),
    .RCSN3(RCSN3), .RA(RA), .Q(Q), .COMPE(COMPE), .MODE(MODE), .ADDIN(ADDIN),
    .MCT(MCT), .FCSN(FCSN), .FA(FA), .FD(FD), .READYN(READYN), .PSOUT(PSOUT),
    .RES_OUT(RES_OUT), .SOUT(SOUT)
  );

  typedef struct {
    logic [4:0]  row;
    logic [1:0]  mode;
    logic [3:0]  rcsn;
    logic [23:0] addin;
    logic [4:0]  mct;
    logic [23:0] exp_ps;
    logic [3:0]  exp_q;
  } vec_t;

  int          n_cmp = 0, n_bad = 0;
  vec_t        tv[15];
  int          bm_row[8], bm_mode[8];
  logic [23:0] bm_addin[8], bm_ps[8];
  logic [3:0]  bm_q[8];
  logic [255:0] ones, a5_lo;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge RCK);
    #1;
  endtask

  task automatic stop_launch();
    RCSN = 1'b1; COMPE = 1'b0; FCSN = 1'b1;
  endtask

  task automatic launch(input logic [4:0] row, input logic [1:0] mode, input logic [3:0] rcsn,
                        input logic [23:0] addin, input logic [4:0] mct);
    RCSN = 1'b0; COMPE = 1'b1; RA = {row, 2'b00}; MODE = mode;
    {RCSN3, RCSN2, RCSN1, RCSN0} = rcsn; ADDIN = addin; MCT = {3'b000, mct};
  endtask

  task automatic wr(input logic [6:0] a, input logic [255:0] d, input logic [255:0] m);
    WCSN = 1'b0; WEN = 1'b0; WA = a; D = d; M = m;
    step();
    WCSN = 1'b1; WEN = 1'b1;
  endtask

  task automatic fwr(input logic [1:0] a, input logic [255:0] d);
    FCSN = 1'b0; FA = a; FD = d;
    step();
    FCSN = 1'b1;
  endtask

  task automatic rd(input logic [6:0] a);
    RCSN = 1'b0; COMPE = 1'b0; RA = a;
    step();
    RCSN = 1'b1;
  endtask

  task automatic run_one(input vec_t v, input int idx);
    int n;
    n = 0;
    launch(v.row, v.mode, v.rcsn, v.addin, v.mct);
    do begin
      step();
      if (n == 0) stop_launch();
      n++;
    end while (READYN && n < 8);
    chk($sformatf("tv%0d_latency", idx), 256'(n), 256'(4));
    chk($sformatf("tv%0d_psout", idx), 256'(PSOUT), 256'(v.exp_ps));
    chk($sformatf("tv%0d_quant", idx), 256'({RES_OUT, SOUT}), 256'(v.exp_q));
  endtask

  // Back-to-back launches; results must appear on consecutive cycles from E3.
  task automatic burst(input int n, input string nm);
    time t0, tl;
    t0 = $time;
    tl = 0;
    for (int c = 0; c < n + 6; c++) begin
      if (c < n) launch(5'(bm_row[c]), 2'(bm_mode[c]), 4'h0, bm_addin[c], 5'd0);
      else stop_launch();
      step();
      if (c >= 3 && c < 3 + n) begin
        chk($sformatf("%s_readyn%0d", nm, c - 3), 256'(READYN), 256'(0));
        chk($sformatf("%s_psout%0d", nm, c - 3), 256'(PSOUT), 256'(bm_ps[c-3]));
        chk($sformatf("%s_quant%0d", nm, c - 3), 256'({RES_OUT, SOUT}), 256'(bm_q[c-3]));
        if (c == 3) tl = $time;
      end else begin
        chk($sformatf("%s_idle%0d", nm, c), 256'(READYN), 256'(1));
        if (c >= 3 + n) chk($sformatf("%s_hold%0d", nm, c), 256'(PSOUT), 256'(bm_ps[n-1]));
      end
    end
    chk($sformatf("%s_lat_ns", nm), 256'(tl - t0), 256'(40));
  endtask

  initial begin
    ones  = '1;
    a5_lo = '0;
    for (int i = 0; i < 16; i++) a5_lo[8*i+:8] = 8'hA5;

    tv[0]  = '{5'd1, 2'd0, 4'b0000, 24'd0,       5'd0,  24'd1024,    4'd15};
    tv[1]  = '{5'd2, 2'd0, 4'b1110, 24'd0,       5'd0,  24'd256,     4'd15};
    tv[2]  = '{5'd3, 2'd0, 4'b0101, 24'd0,       5'd0,  24'd512,     4'd15};
    tv[3]  = '{5'd1, 2'd0, 4'b0000, 24'hFFF000,  5'd0,  24'hFFF400,  4'd0};
    tv[4]  = '{5'd1, 2'd0, 4'b0000, 24'd0,       5'd7,  24'd1024,    4'd8};
    tv[5]  = '{5'd1, 2'd0, 4'b0000, 24'd0,       5'd6,  24'd1024,    4'd15};
    tv[6]  = '{5'd1, 2'd0, 4'b0000, 24'd0,       5'd10, 24'd1024,    4'd1};
    tv[7]  = '{5'd0, 2'd1, 4'b0000, 24'd0,       5'd9,  24'd4608,    4'd9};
    tv[8]  = '{5'd4, 2'd3, 4'b1110, 24'd0,       5'd0,  24'd2080800, 4'd15};
    tv[9]  = '{5'd0, 2'd2, 4'b0111, 24'd3,       5'd12, 24'd14403,   4'd3};
    tv[10] = '{5'd1, 2'd0, 4'b0000, 24'hFFFC00,  5'd0,  24'd0,       4'd0};
    tv[11] = '{5'd2, 2'd0, 4'b1111, 24'd15,      5'd0,  24'd15,      4'd15};
    tv[12] = '{5'd2, 2'd0, 4'b1111, 24'd16,      5'd0,  24'd16,      4'd15};
    tv[13] = '{5'd3, 2'd3, 4'b0000, 24'h810000,  5'd4,  24'd128,     4'd8};
    tv[14] = '{5'd2, 2'd0, 4'b1111, 24'hFFFFF0,  5'd2,  24'hFFFFF0,  4'd0};

    RESETn = 1'b1; WCSN = 1'b1; WEN = 1'b1; RCSN = 1'b1; COMPE = 1'b0; FCSN = 1'b1;
    {RCSN3, RCSN2, RCSN1, RCSN0} = 4'h0;
    WA = '0; RA = '0; D = '0; M = '0; FD = '0; FA = '0; MODE = '0; ADDIN = '0; MCT = '0;
    step(); step();
    RESETn = 1'b0;
    chk("rst_readyn", 256'(READYN), 256'(1));
    chk("rst_psout", 256'(PSOUT), 256'(0));
    chk("rst_quant", 256'({RES_OUT, SOUT}), 256'(0));
    chk("rst_q", Q, 256'(0));

    wr(7'd0, a5_lo, ones);
    rd(7'd0);
    chk("read_a5", Q, a5_lo);
    step();
    chk("q_hold", Q, a5_lo);
    // Write and read of the same word in one cycle: read sees the old word.
    WCSN = 1'b0; WEN = 1'b0; WA = 7'd0; D = ones; M = ones;
    RCSN = 1'b0; COMPE = 1'b0; RA = 7'd0;
    step();
    WCSN = 1'b1; WEN = 1'b1; RCSN = 1'b1;
    chk("rbw_old", Q, a5_lo);
    rd(7'd0);
    chk("rbw_new", Q, ones);
    wr(7'd5, ones, ones);
    wr(7'd5, 256'h0, 256'h0F);
    rd(7'd5);
    chk("masked_wr", Q, ~256'hF);

    wr(7'd0, 256'h00010001, ones);
    wr(7'd1, 256'h00010010, ones);
    wr(7'd2, 256'h00010100, ones);
    wr(7'd3, 256'h00011000, ones);
    fwr(2'd0, 256'h00011111);
    fwr(2'd1, 256'h0);
    fwr(2'd2, 256'h0);
    fwr(2'd3, 256'h0);
    // Only sec0 features are non-zero: nibbles 0 and 4 give 1*1 each, plus ADDIN=5.
    bm_row[0] = 0; bm_mode[0] = 2; bm_addin[0] = 24'd5; bm_ps[0] = 24'd7; bm_q[0] = 4'd7;
    burst(1, "dot4b");
    chk("q_no_launch_update", Q, ~256'hF);

    for (int a = 0; a < 20; a++) wr(7'(a), ones, ones);
    for (int f = 0; f < 4; f++) fwr(2'(f), ones);

    for (int i = 0; i < 5; i++) begin
      bm_row[i] = i; bm_mode[i] = 0; bm_addin[i] = '0; bm_ps[i] = 24'd1024; bm_q[i] = 4'd15;
    end
    burst(5, "b2b1b");

    bm_row[0] = 0; bm_mode[0] = 0; bm_ps[0] = 24'd1024;
    bm_row[1] = 1; bm_mode[1] = 2; bm_ps[1] = 24'd57600;
    bm_row[2] = 2; bm_mode[2] = 0; bm_ps[2] = 24'd1024;
    bm_row[3] = 3; bm_mode[3] = 3; bm_ps[3] = 24'd8323200;
    for (int i = 0; i < 4; i++) begin bm_addin[i] = '0; bm_q[i] = 4'd15; end
    burst(4, "mixed");

    for (int i = 0; i < 15; i++) run_one(tv[i], i);

    // Feature write coinciding with a launch: the launch uses the old features.
    FCSN = 1'b0; FA = 2'd0; FD = 256'h0;
    run_one('{5'd1, 2'd0, 4'b0000, 24'd0, 5'd0, 24'd1024, 4'd15}, 100);
    run_one('{5'd1, 2'd0, 4'b0000, 24'd0, 5'd0, 24'd768,  4'd15}, 101);

    launch(5'd1, 2'd0, 4'h0, 24'd0, 5'd0);
    step();
    launch(5'd2, 2'd3, 4'h0, 24'd0, 5'd0);
    step();
    stop_launch();
    RESETn = 1'b1;
    step();
    RESETn = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("flight_drop%0d", c), 256'(READYN), 256'(1));
    end
    chk("flight_psout", 256'(PSOUT), 256'(0));
    chk("flight_quant", 256'({RES_OUT, SOUT}), 256'(0));
    chk("flight_q", Q, 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
